// File: rtl/fp_mult_arbiter_pkg.sv
// Purpose: shared types and constants for the FP multiplier arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: round_values enum, status flag width and bit indices, control FSM state enum.
package fp_mult_pkg;

  // Rounding modes understood by the shared multiplier.
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } round_values;

  // Status vector layout: {inexact, huge, tiny, nan, inf, zero}.
  localparam int STATUS_W   = 6;
  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Purpose: bundle of requester, multiplier and control signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready per requester; responses carry no backpressure.
// Modports: slave = arbiter side, master = requesters + multiplier + controller side.
// Optional: FP_MULT_ARB_STICKY_EN adds sticky_status / sticky_clr.
interface fp_mult_arbiter_if #(
  parameter int NREQ = 4
);
  import fp_mult_pkg::*;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*32-1:0]       req_a;
  logic [NREQ*32-1:0]       req_b;
  logic                     mul_valid;
  logic [31:0]              mul_a;
  logic [31:0]              mul_b;
  logic [31:0]              mul_z;
  logic [STATUS_W-1:0]      mul_status;
  logic [NREQ-1:0]          rsp_valid;
  logic [31:0]              rsp_z;
  logic [STATUS_W-1:0]      rsp_status;
  logic                     drain_req;
  logic                     drain_done;
  logic                     busy;
`ifdef FP_MULT_ARB_STICKY_EN
  logic [NREQ*STATUS_W-1:0] sticky_status;
  logic [NREQ-1:0]          sticky_clr;

  modport slave (
    input  req_valid, req_a, req_b, mul_z, mul_status, drain_req, sticky_clr,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_z, rsp_status,
           drain_done, busy, sticky_status
  );
  modport master (
    output req_valid, req_a, req_b, mul_z, mul_status, drain_req, sticky_clr,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_z, rsp_status,
           drain_done, busy, sticky_status
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, mul_z, mul_status, drain_req,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_z, rsp_status,
           drain_done, busy
  );
  modport master (
    output req_valid, req_a, req_b, mul_z, mul_status, drain_req,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_z, rsp_status,
           drain_done, busy
  );
`endif

endinterface

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Purpose: round-robin pick of the first active request at or after ptr (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; the caller masks gnt when it cannot issue.
// Ports: req (NREQ), ptr (ID_W) in; gnt one-hot (NREQ), gnt_id encoded (ID_W) out.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Purpose: share one pipelined FP multiplier between NREQ requesters, round-robin, with drain.
// Latency: accept at t -> mul_valid at t+1 -> rsp_valid[id] at t+LATENCY+2.
// Backpressure: req_ready is the grant; no backpressure on responses; drain_req blocks grants.
// Ports: clk, rst (sync, active high), bus (fp_mult_arbiter_if.slave).
// Optional: FP_MULT_ARB_STICKY_EN adds per-requester sticky status accumulation.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 3,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  fp_mult_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 3);

  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_DRAIN   = DRAIN;
  localparam logic [1:0] S_DRAINED = DRAINED;

  logic [1:0]          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    inflight;
  logic [NREQ-1:0]     gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                grant_en;
  logic                accept;
  logic                rsp_any;

  logic                mul_valid_q;
  logic [31:0]         mul_a_q;
  logic [31:0]         mul_b_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [31:0]         rsp_z_q;
  logic [STATUS_W-1:0] rsp_status_q;

  // Tag stage k lines up with the multiplier's k-th cycle after issue;
  // stage LATENCY is the one aligned with mul_z.
  logic [LATENCY:0]    tag_vld;
  logic [ID_W-1:0]     tag_id [LATENCY+1];

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // drain_req masks grants in the cycle it rises, so drain beats a coincident request.
  assign grant_en      = !rst && (state == S_RUN) && !bus.drain_req;
  assign bus.req_ready = grant_en ? gnt : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign rsp_any       = |rsp_valid_q;

  // Issue register: operands hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        mul_a_q <= bus.req_a[int'(gnt_id)*32 +: 32];
        mul_b_q <= bus.req_b[int'(gnt_id)*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Reset clears every valid bit so nothing issued before reset ever responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_vld   <= {tag_vld[LATENCY-1:0], accept};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_z_q      <= '0;
      rsp_status_q <= '0;
    end else begin
      rsp_valid_q <= tag_vld[LATENCY] ? (NREQ'(1) << tag_id[LATENCY]) : '0;
      if (tag_vld[LATENCY]) begin
        rsp_z_q      <= bus.mul_z;
        rsp_status_q <= bus.mul_status;
      end
    end
  end

  // Counts operations from accept until their response strobe; peaks at LATENCY+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, rsp_any})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:     if (bus.drain_req) state <= S_DRAIN;
        S_DRAIN:   if ((inflight == '0) && !rsp_any) state <= S_DRAINED;
        S_DRAINED: if (!bus.drain_req) state <= S_RUN;
        default:   state <= S_RUN;
      endcase
    end
  end

  assign bus.mul_valid  = mul_valid_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.drain_done = (state == S_DRAINED);
  assign bus.busy       = (inflight != '0);

`ifdef FP_MULT_ARB_STICKY_EN
  logic [NREQ*STATUS_W-1:0] sticky_q;

  // A clear coinciding with a response keeps only the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.sticky_clr[i]) begin
          sticky_q[i*STATUS_W +: STATUS_W] <= rsp_valid_q[i] ? rsp_status_q : '0;
        end else if (rsp_valid_q[i]) begin
          sticky_q[i*STATUS_W +: STATUS_W] <= sticky_q[i*STATUS_W +: STATUS_W] | rsp_status_q;
        end
      end
    end
  end

  assign bus.sticky_status = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Purpose: directed self-checking bench for fp_mult_arbiter with a table-driven multiplier stub.
// Latency: stub returns mul_z/mul_status LATENCY cycles after mul_valid.
// Backpressure: bench accepts every response.
`timescale 1ns/1ps
module tb_fp_mult_arbiter;
  import fp_mult_pkg::*;

  localparam int NREQ    = 4;
  localparam int LATENCY = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter_if #(.NREQ(NREQ)) bus ();

  fp_mult_arbiter #(
    .NREQ    (NREQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Multiplier stub: two real IEEE cases, otherwise z = a ^ b, status = b[5:0].
  function automatic logic [37:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {6'b000000, 32'h4000_0000};
    if (a == 32'h7F7F_FFFF && b == 32'h4000_0000) return {6'b110010, 32'h7F80_0000};
    return {b[5:0], a ^ b};
  endfunction

  logic [37:0] mres;
  logic [31:0] pz [1:LATENCY];
  logic [5:0]  ps [1:LATENCY];

  assign mres = mul_model(bus.mul_a, bus.mul_b);

  always @(posedge clk) begin
    pz[1] <= mres[31:0];
    ps[1] <= mres[37:32];
    for (int k = 2; k <= LATENCY; k++) begin
      pz[k] <= pz[k-1];
      ps[k] <= ps[k-1];
    end
  end

  assign bus.mul_z      = pz[LATENCY];
  assign bus.mul_status = ps[LATENCY];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Back-to-back expected results, hand-computed from the stub for requesters 0..3.
  logic [31:0] b2b_z [4];
  logic [5:0]  b2b_s [4];

  initial begin
    b2b_z[0] = 32'h5000_0001; b2b_s[0] = 6'd1;
    b2b_z[1] = 32'h5000_0003; b2b_s[1] = 6'd2;
    b2b_z[2] = 32'h5000_0001; b2b_s[2] = 6'd3;
    b2b_z[3] = 32'h5000_0007; b2b_s[3] = 6'd4;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.drain_req = 1'b0;
`ifdef FP_MULT_ARB_STICKY_EN
    bus.sticky_clr = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = 32'h1000_0000 + i;
      bus.req_b[32*i +: 32] = 32'h4000_0000 | (i + 1);
    end

    // Reset state, with requests present to prove the grant is held off.
    repeat (2) @(negedge clk);
    bus.req_valid = 4'hF; #1;
    chk("rst_ready",      bus.req_ready,  0);
    chk("rst_mul_valid",  bus.mul_valid,  0);
    chk("rst_mul_a",      bus.mul_a,      0);
    chk("rst_rsp_valid",  bus.rsp_valid,  0);
    chk("rst_rsp_z",      bus.rsp_z,      0);
    chk("rst_rsp_status", bus.rsp_status, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_busy",       bus.busy,       0);

    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3, responses 5 cycles later.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      bus.req_valid = (k < 8) ? 4'hF : 4'h0; #1;
      if (k < 8) chk("b2b_gnt", bus.req_ready, 4'b0001 << (k % 4));
      if (k >= 1 && k <= 8) begin
        chk("b2b_mul_valid", bus.mul_valid, 1);
        chk("b2b_mul_a", bus.mul_a, 32'h1000_0000 + ((k - 1) % 4));
      end
      if (k == 9) chk("b2b_mul_idle", bus.mul_valid, 0);
      if (k == 7) chk("b2b_busy", bus.busy, 1);
      if (k >= 5 && k < 13) begin
        chk("b2b_rsp_valid",  bus.rsp_valid,  4'b0001 << ((k - 5) % 4));
        chk("b2b_rsp_z",      bus.rsp_z,      b2b_z[(k - 5) % 4]);
        chk("b2b_rsp_status", bus.rsp_status, b2b_s[(k - 5) % 4]);
      end
      if (k == 13) begin
        chk("b2b_rsp_end", bus.rsp_valid, 0);
        chk("b2b_idle",    bus.busy,      0);
      end
    end

    // Requester 2 alone: 1.0 * 2.0 = 2.0, response 5 cycles after grant.
    @(negedge clk);
    bus.req_a[64 +: 32] = 32'h3F80_0000;
    bus.req_b[64 +: 32] = 32'h4000_0000;
    bus.req_valid = 4'b0100; #1;
    chk("r2_gnt", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = 4'b0000; #1;
    chk("r2_mul_valid", bus.mul_valid, 1);
    chk("r2_mul_a",     bus.mul_a,     32'h3F80_0000);
    chk("r2_mul_b",     bus.mul_b,     32'h4000_0000);
    chk("r2_busy",      bus.busy,      1);
    @(negedge clk); #1;
    chk("r2_mul_drop", bus.mul_valid, 0);
    chk("r2_mul_hold", bus.mul_a,     32'h3F80_0000);
    repeat (2) @(negedge clk); #1;
    chk("r2_rsp_early", bus.rsp_valid, 0);
    @(negedge clk); #1;
    chk("r2_rsp_valid",  bus.rsp_valid,  4'b0100);
    chk("r2_rsp_z",      bus.rsp_z,      32'h4000_0000);
    chk("r2_rsp_status", bus.rsp_status, 0);
    @(negedge clk); #1;
    chk("r2_rsp_pulse", bus.rsp_valid, 0);
    chk("r2_rsp_hold",  bus.rsp_z,     32'h4000_0000);
    chk("r2_idle",      bus.busy,      0);

    // Requester 1 overflow: FLT_MAX * 2.0 -> +inf with inf/huge/inexact.
    @(negedge clk);
    bus.req_a[32 +: 32] = 32'h7F7F_FFFF;
    bus.req_b[32 +: 32] = 32'h4000_0000;
    bus.req_valid = 4'b0010; #1;
    chk("ovf_gnt", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    repeat (4) @(negedge clk); #1;
    chk("ovf_rsp_valid",  bus.rsp_valid,          4'b0010);
    chk("ovf_rsp_z",      bus.rsp_z,              32'h7F80_0000);
    chk("ovf_rsp_status", bus.rsp_status,         6'b110010);
    chk("ovf_inf_flag",   bus.rsp_status[ST_INF], 1);

    // Drain: one op in flight (requester 2), then drain raised with all valid.
    @(negedge clk);
    bus.req_valid = 4'hF; #1;
    chk("drn_pre_gnt", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.drain_req = 1'b1; #1;
    chk("drn_mask", bus.req_ready, 0);
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk); #1;
      chk("drn_no_gnt", bus.req_ready,  0);
      chk("drn_done",   bus.drain_done, (d == 6) ? 1 : 0);
      if (d == 4) chk("drn_last_rsp", bus.rsp_valid, 4'b0100);
    end
    @(negedge clk);
    bus.drain_req = 1'b0; #1;
    chk("drn_exit_no_gnt", bus.req_ready,  0);
    chk("drn_exit_done",   bus.drain_done, 1);
    @(negedge clk); #1;
    chk("drn_resume_ptr",  bus.req_ready,  4'b1000);
    chk("drn_resume_done", bus.drain_done, 0);
    @(negedge clk);
    bus.req_valid = 4'h0;
    repeat (6) @(negedge clk); #1;
    chk("drn_settle", bus.busy, 0);

    // Reset while three ops are in flight: none may respond, pointer returns to 0.
    for (int r = 0; r < 3; r++) begin
      if (r > 0) @(negedge clk);
      bus.req_valid = 4'hF; #1;
      chk("mrst_gnt", bus.req_ready, 4'b0001 << r);
    end
    @(negedge clk);
    bus.req_valid = 4'h0; #1;
    chk("mrst_busy_pre", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("mrst_busy",      bus.busy,      0);
    chk("mrst_mul_valid", bus.mul_valid, 0);
    for (int r = 0; r < 5; r++) begin
      chk("mrst_no_rsp", bus.rsp_valid, 0);
      @(negedge clk); #1;
    end
    bus.req_valid = 4'hF; #1;
    chk("mrst_ptr", bus.req_ready, 4'b0001);

    // Single requester held valid: granted every cycle.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      bus.req_valid = 4'b0001; #1;
      chk("single_gnt", bus.req_ready, 4'b0001);
      chk("single_mul", bus.mul_valid, 1);
    end
    @(negedge clk);
    bus.req_valid = 4'h0;
    repeat (7) @(negedge clk); #1;
    chk("single_idle", bus.busy, 0);

`ifdef FP_MULT_ARB_STICKY_EN
    // Two responses to requester 0 (inexact then tiny) accumulate.
    @(negedge clk);
    bus.sticky_clr = 4'b0001;
    bus.req_a[0 +: 32] = 32'h0000_1000;
    bus.req_b[0 +: 32] = 32'h0000_0020;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.sticky_clr = 4'b0000;
    bus.req_b[0 +: 32] = 32'h0000_0008;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    repeat (5) @(negedge clk); #1;
    chk("sticky_acc",   bus.sticky_status[5:0],  6'b101000);
    chk("sticky_other", bus.sticky_status[23:6], 0);
    // Clear coincident with a zero-flag response keeps only the new flags.
    @(negedge clk);
    bus.req_b[0 +: 32] = 32'h0000_0001;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    bus.sticky_clr = 4'b0001; #1;
    chk("sticky_clr_rsp", bus.rsp_valid, 4'b0001);
    @(negedge clk);
    bus.sticky_clr = 4'b0000; #1;
    chk("sticky_clr_set", bus.sticky_status[5:0], 6'b000001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
